// File: rtl/n_accum.sv
// rtl/n_accum.sv - lane-reduction float_add tree plus per-packet float accumulator (option: NN_ACC_RELU_EN)
module n_accum #(
    parameter int CELL_N     = 8,
    parameter int D_LEN      = 32,
    parameter int ADD_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [CELL_N*D_LEN-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [D_LEN-1:0]        out_data,
    input  logic                    out_ready
);
    localparam int EW  = (D_LEN == 64) ? 11 : (D_LEN == 16) ? 5 : 8;
    localparam int MW  = D_LEN - EW - 1;
    localparam int LV  = $clog2(CELL_N);
    localparam int T   = LV * ADD_LAT;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH) + 2;
    localparam int NW  = $clog2(ADD_LAT) + 1;

    // IEEE-style add, round-to-nearest-even, subnormals kept, NaN canonicalised.
    function automatic logic [D_LEN-1:0] fadd(input logic [D_LEN-1:0] a, input logic [D_LEN-1:0] b);
        logic [D_LEN-1:0] x, y, r;
        logic [EW-1:0]    ex, ey;
        logic [MW+4:0]    ax, ay, sum;
        logic [MW+1:0]    rm;
        logic             sticky;
        int               d, e;
        if (a[D_LEN-2:0] >= b[D_LEN-2:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = x[D_LEN-2:MW];
        ey = y[D_LEN-2:MW];
        ax = {1'b0, |ex, x[MW-1:0], 3'b000};
        ay = {1'b0, |ey, y[MW-1:0], 3'b000};
        e  = (ex == '0) ? 1 : int'(ex);
        d  = e - ((ey == '0) ? 1 : int'(ey));
        sticky = 1'b0;
        for (int i = 0; i < MW + 5; i++)
            if (i < d) sticky = sticky | ay[i];
        ay = (d > MW + 4) ? '0 : (ay >> d);
        ay[0] = ay[0] | sticky;
        sum = (x[D_LEN-1] == y[D_LEN-1]) ? ax + ay : ax - ay;
        if (sum[MW+4]) begin
            sum = {1'b0, sum[MW+4:2], sum[1] | sum[0]};
            e   = e + 1;
        end else begin
            for (int i = 0; i < MW + 3; i++)
                if (!sum[MW+3] && e > 1) begin
                    sum = sum << 1;
                    e   = e - 1;
                end
        end
        rm = {1'b0, sum[MW+3:3]};
        if (sum[2] && (sum[1] || sum[0] || rm[0])) rm = rm + (MW+2)'(1);
        if (rm[MW+1]) begin
            rm = rm >> 1;
            e  = e + 1;
        end
        if (&ex)
            r = (x[MW-1:0] != '0 || (&ey && x[D_LEN-1] != y[D_LEN-1])) ?
                {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}} : x;
        else if (sum == '0)
            r = {x[D_LEN-1] & y[D_LEN-1], {(D_LEN-1){1'b0}}};
        else if (e >= (1 << EW) - 1)
            r = {x[D_LEN-1], {EW{1'b1}}, {MW{1'b0}}};
        else
            r = {x[D_LEN-1], rm[MW] ? EW'(e) : EW'(0), rm[MW-1:0]};
        return r;
    endfunction

    logic accept;
    assign accept = in_valid && in_ready;

    // Reduction tree: data flows every cycle, vpipe/lpipe tag the real beats.
    logic [CELL_N-1:0][D_LEN-1:0] lvl [LV+1];
    assign lvl[0] = in_data;

    for (genvar k = 0; k < LV; k++) begin : g_lvl
        for (genvar j = 0; j < CELL_N; j++) begin : g_lane
            if (j < (CELL_N >> (k + 1))) begin : g_add
                logic [D_LEN-1:0] pipe [ADD_LAT];
                always_ff @(posedge clk) begin
                    pipe[0] <= fadd(lvl[k][2*j], lvl[k][2*j+1]);
                    for (int s = 1; s < ADD_LAT; s++) pipe[s] <= pipe[s-1];
                end
                assign lvl[k+1][j] = pipe[ADD_LAT-1];
            end else begin : g_pad
                assign lvl[k+1][j] = '0;
            end
        end
    end

    logic [T-1:0]  vpipe, lpipe;
    logic [CW-1:0] inflight, fifo_count;
    logic          run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe    <= '0;
            lpipe    <= '0;
            inflight <= '0;
            run      <= 1'b0;
        end else begin
            run      <= 1'b1;
            vpipe[0] <= accept;
            lpipe[0] <= accept && in_last;
            for (int s = 1; s < T; s++) begin
                vpipe[s] <= vpipe[s-1];
                lpipe[s] <= lpipe[s-1];
            end
            case ({accept, vpipe[T-1]})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Reserving FIFO space for every beat still in the tree makes overflow impossible.
    assign in_ready = run && ((fifo_count + inflight) < CW'(FIFO_DEPTH));

    logic [D_LEN:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic            pop, push, fifo_empty;
    logic [D_LEN:0]  head;

    assign push       = vpipe[T-1];
    assign fifo_empty = (fifo_count == '0);
    assign head       = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {lpipe[T-1], lvl[LV][0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_DONE} state_t;
    state_t          state, next_state;
    logic [D_LEN-1:0] acc, opnd;
    logic            wlast, load, issue, fin;
    logic [NW-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (!fifo_empty) next_state = head[D_LEN] ? S_DONE : S_ACC;
            S_ACC:  if (!fifo_empty) next_state = S_WAIT;
            S_WAIT: if (cnt == NW'(ADD_LAT - 1)) next_state = wlast ? S_DONE : S_ACC;
            S_DONE: if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        load      = (state == S_IDLE) && !fifo_empty;
        issue     = (state == S_ACC) && !fifo_empty;
        pop       = load || issue;
        fin       = (state == S_WAIT) && (cnt == NW'(ADD_LAT - 1));
        out_valid = (state == S_DONE);
`ifdef NN_ACC_RELU_EN
        out_data  = acc[D_LEN-1] ? '0 : acc;
`else
        out_data  = acc;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opnd  <= '0;
            wlast <= 1'b0;
            cnt   <= '0;
        end else begin
            if (load) acc <= head[D_LEN-1:0];
            if (issue) begin
                opnd  <= head[D_LEN-1:0];
                wlast <= head[D_LEN];
                cnt   <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + NW'(1);
            end
            if (fin) acc <= fadd(acc, opnd);
        end
    end
endmodule

// File: tb/tb_n_accum.sv
// tb/tb_n_accum.sv - directed self-checking bench for n_accum (CELL_N=8, IEEE single, ADD_LAT=3)
module tb_n_accum;
    localparam logic [31:0] F1  = 32'h3F800000, F2 = 32'h40000000, FN1 = 32'hBF800000;
    localparam logic [31:0] FH  = 32'h3F000000, FQ = 32'h3E800000, FN2 = 32'hC0000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [255:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [31:0]  out_data;

    int           checks = 0, errors = 0;
    logic [31:0]  got [$];
    bit           stall_mode = 0, stall_seen = 0;
    int           lat;
    logic [255:0] seq;
    logic [31:0]  lane_v [12] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                  32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
    logic [31:0]  sum_v  [12] = '{32'h41000000, 32'h41800000, 32'h41C00000, 32'h42000000,
                                  32'h42200000, 32'h42400000, 32'h42600000, 32'h42800000,
                                  32'h42900000, 32'h42A00000, 32'h42B00000, 32'h42C00000};

    always #5 clk = ~clk;

    n_accum dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    // Record every handshake; sampled mid-low-phase, after bench input updates.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && out_valid && out_ready) got.push_back(out_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] splat(input logic [31:0] v);
        return {8{v}};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
    task automatic send_beat(input logic [255:0] d, input logic last);
        int waited = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            if (stall_mode && !stall_seen && waited == 20) begin
                chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_out_data", out_data, 32'h41000000);
                chk("stall_no_output", 32'(got.size()), 32'd0);
                stall_seen = 1;
                out_ready  = 1'b1;
            end
            @(negedge clk);
            waited++;
        end
        chk("accept_in_time", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_outs(input int n);
        int waited = 0;
        while (got.size() < n && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("out_count", 32'(got.size()), 32'(n));
    endtask

    initial begin
        seq = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
               32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", {31'b0, in_ready}, 32'd1);

        // Single beat of 1.0s: 8.0 after T+2 cycles
        send_beat(splat(F1), 1'b1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("single_latency", 32'(lat), 32'd11);
        chk("single_data_live", out_data, 32'h41000000);
        wait_outs(1);
        chk("single_sum", got[0], 32'h41000000);

        // Two beats: nothing after beat 1, 16.0 after beat 2
        got.delete();
        send_beat(splat(F1), 1'b0);
        idle(25);
        chk("no_early_out", 32'(got.size()), 32'd0);
        send_beat(splat(F1), 1'b1);
        idle(0);
        wait_outs(1);
        chk("two_beat_sum", got[0], 32'h41800000);

        // Negative sum and the optional clamp
        got.delete();
        send_beat(splat(FN1), 1'b1);
        idle(0);
        wait_outs(1);
`ifdef NN_ACC_RELU_EN
        chk("neg_sum", got[0], 32'h00000000);
`else
        chk("neg_sum", got[0], 32'hC1000000);
`endif

        // Exact cancellation gives +0; RNE tie 2^24+3 rounds to even 2^24+4
        got.delete();
        send_beat({4{FN1, F1}}, 1'b1);
        send_beat({192'b0, 32'h40400000, 32'h4B800000}, 1'b1);
        idle(0);
        wait_outs(2);
        chk("cancel_zero", got[0], 32'h00000000);
        chk("round_even", got[1], 32'h4B800002);

        // Three beats 36 - 16 + 2 = 22
        got.delete();
        send_beat(seq, 1'b0);
        send_beat(splat(FN2), 1'b0);
        send_beat(splat(FQ), 1'b1);
        idle(0);
        wait_outs(1);
        chk("three_beat_sum", got[0], 32'h41B00000);

        // Back-to-back packets with in_valid held high
        got.delete();
        send_beat(seq, 1'b0);
        send_beat(splat(F1), 1'b1);
        send_beat(splat(FH), 1'b1);
        send_beat(splat(F2), 1'b0);
        send_beat(splat(FN1), 1'b0);
        send_beat(splat(FQ), 1'b1);
        idle(0);
        wait_outs(3);
        chk("b2b_pkt_a", got[0], 32'h42300000);
        chk("b2b_pkt_b", got[1], 32'h40800000);
        chk("b2b_pkt_c", got[2], 32'h41200000);

        // Downstream stall with 12 single-beat packets, then release
        got.delete();
        out_ready  = 1'b0;
        stall_mode = 1;
        for (int k = 0; k < 12; k++) send_beat(splat(lane_v[k]), 1'b1);
        idle(0);
        stall_mode = 0;
        chk("stall_backpressure", {31'b0, stall_seen}, 32'd1);
        wait_outs(12);
        for (int k = 0; k < 12; k++) chk($sformatf("stall_pkt_%0d", k), got[k], sum_v[k]);

        // Reset in the middle of a packet discards it
        got.delete();
        send_beat(splat(F1), 1'b0);
        send_beat(splat(F1), 1'b0);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(splat(F2), 1'b1);
        idle(0);
        wait_outs(1);
        idle(30);
        chk("midrst_count", 32'(got.size()), 32'd1);
        chk("midrst_sum", got[0], 32'h41800000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
